// File: rtl/cw_decoder.sv
// Morse (CW) keyer decoder: times marks/spaces in ms ticks, classifies dots/dashes,
// looks up the ASCII character and presents it through a single-entry holding register.
module cw_decoder #(
  parameter int unsigned MAX_ELEM = 6,
  parameter int unsigned CNT_W    = 11
) (
  input  logic       IF_clk,
  input  logic       rstb,
  input  logic       do1k,
  input  logic       enable,
  input  logic       cw_key,
  input  logic [9:0] DotOnTime,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overflow,
  input  logic       overflow_clr
);

  localparam int unsigned TW = CNT_W + 2;
  localparam int unsigned EW = $clog2(MAX_ELEM + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMark = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;
  localparam logic [1:0] StWord = 2'd3;

  localparam logic [MAX_ELEM:0] CodeEmpty = (MAX_ELEM + 1)'(1);
  localparam logic [EW-1:0]     ElemMax   = EW'(MAX_ELEM);

  logic             key_meta_q, key_sync_q, key_prev_q;
  logic [1:0]       fill_q;
  logic             armed_q, armed_d;
  logic             rise, fall;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] mark_q, mark_d, space_q, space_d;
  logic [CNT_W-1:0] mark_inc, space_inc;
  logic [MAX_ELEM:0] code_q, code_d;
  logic [EW-1:0]    elem_q, elem_d;
  logic             err_q, err_d;

  logic [TW-1:0]    t_eff, thr_char, thr_word;
  logic             is_dash;

  logic             emit;
  logic [7:0]       emit_char;

  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             xfer, ovf_set;

  function automatic logic [7:0] lookup(input logic [MAX_ELEM:0] code);
    // Code is a leading-1 sentinel followed by elements, oldest first (dot=0, dash=1).
    case (32'(code))
      2:   lookup = "E";
      3:   lookup = "T";
      4:   lookup = "I";
      5:   lookup = "A";
      6:   lookup = "N";
      7:   lookup = "M";
      8:   lookup = "S";
      9:   lookup = "U";
      10:  lookup = "R";
      11:  lookup = "W";
      12:  lookup = "D";
      13:  lookup = "K";
      14:  lookup = "G";
      15:  lookup = "O";
      16:  lookup = "H";
      17:  lookup = "V";
      18:  lookup = "F";
      20:  lookup = "L";
      22:  lookup = "P";
      23:  lookup = "J";
      24:  lookup = "B";
      25:  lookup = "X";
      26:  lookup = "C";
      27:  lookup = "Y";
      28:  lookup = "Z";
      29:  lookup = "Q";
      32:  lookup = "5";
      33:  lookup = "4";
      35:  lookup = "3";
      39:  lookup = "2";
      47:  lookup = "1";
      48:  lookup = "6";
      49:  lookup = "=";
      50:  lookup = "/";
      56:  lookup = "7";
      60:  lookup = "8";
      62:  lookup = "9";
      63:  lookup = "0";
      76:  lookup = "?";
      85:  lookup = ".";
      115: lookup = ",";
      default: lookup = 8'h2A;
    endcase
  endfunction

  // Thresholds are held two bits wider than the counters so 5T never wraps.
  assign t_eff    = (DotOnTime == 10'd0) ? TW'(1) : TW'(DotOnTime);
  assign thr_char = t_eff << 1;
  assign thr_word = (t_eff << 2) + t_eff;

  assign mark_inc  = (mark_q == '1) ? mark_q : mark_q + 1'b1;
  assign space_inc = (space_q == '1) ? space_q : space_q + 1'b1;
  assign is_dash   = TW'(mark_q) >= thr_char;

  // A key held down across reset must not count as a fresh rising edge.
  assign armed_d = armed_q | (fill_q[1] & ~key_sync_q);
  assign rise    = armed_q & key_sync_q & ~key_prev_q;
  assign fall    = key_prev_q & ~key_sync_q;

  always_comb begin
    state_d   = state_q;
    mark_d    = mark_q;
    space_d   = space_q;
    code_d    = code_q;
    elem_d    = elem_q;
    err_d     = err_q;
    emit      = 1'b0;
    emit_char = 8'h00;
    if (!enable) begin
      state_d = StIdle;
      mark_d  = '0;
      space_d = '0;
      code_d  = CodeEmpty;
      elem_d  = '0;
      err_d   = 1'b0;
    end else if (rise) begin
      state_d = StMark;
      mark_d  = '0;
    end else begin
      case (state_q)
        StMark: begin
          if (fall) begin
            if (elem_q == ElemMax) begin
              err_d = 1'b1;
            end else begin
              code_d = {code_q[MAX_ELEM-1:0], is_dash};
              elem_d = elem_q + 1'b1;
            end
            space_d = '0;
            state_d = StGap;
          end else if (do1k) begin
            mark_d = mark_inc;
          end
        end
        StGap: begin
          if (do1k) begin
            space_d = space_inc;
            if (TW'(space_inc) >= thr_char) begin
              emit      = 1'b1;
              emit_char = err_q ? 8'h2A : lookup(code_q);
              code_d    = CodeEmpty;
              elem_d    = '0;
              err_d     = 1'b0;
              state_d   = StWord;
            end
          end
        end
        StWord: begin
          if (do1k) begin
            space_d = space_inc;
            if (TW'(space_inc) >= thr_word) begin
              emit      = 1'b1;
              emit_char = 8'h20;
              state_d   = StIdle;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    xfer    = valid_q & char_ready;
    data_d  = data_q;
    valid_d = valid_q & ~xfer;
    ovf_set = 1'b0;
    if (emit) begin
      if (!valid_q || xfer) begin
        data_d  = emit_char;
        valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
    ovf_d = ovf_set | (ovf_q & ~overflow_clr);
  end

  always_ff @(posedge IF_clk or negedge rstb) begin
    if (!rstb) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_prev_q <= 1'b0;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= StIdle;
      mark_q     <= '0;
      space_q    <= '0;
      code_q     <= CodeEmpty;
      elem_q     <= '0;
      err_q      <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      key_meta_q <= cw_key;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      fill_q     <= {fill_q[0], 1'b1};
      armed_q    <= armed_d;
      state_q    <= state_d;
      mark_q     <= mark_d;
      space_q    <= space_d;
      code_q     <= code_d;
      elem_q     <= elem_d;
      err_q      <= err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign char_data  = data_q;
  assign char_valid = valid_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cw_decoder.sv
// Scoreboard bench for cw_decoder: stimulus pushes expected characters, a monitor pops
// and compares on every char_valid && char_ready transfer.
module tb_cw_decoder;

  localparam int MaxElem = 6;
  localparam int MsClk   = 5;

  logic       IF_clk = 1'b0;
  logic       rstb, do1k, enable, cw_key, char_ready, overflow_clr;
  logic [9:0] DotOnTime;
  logic [7:0] char_data;
  logic       char_valid, overflow;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  exp_q[$];

  string morse [41] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----",
                        "..---", "...--", "....-", ".....", "-....", "--...", "---..",
                        "----.", ".-.-.-", "--..--", "..--..", "-..-.", "-...-"};

  cw_decoder #(.MAX_ELEM(MaxElem), .CNT_W(11)) u_dut (
    .IF_clk       (IF_clk),
    .rstb         (rstb),
    .do1k         (do1k),
    .enable       (enable),
    .cw_key       (cw_key),
    .DotOnTime    (DotOnTime),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 IF_clk = ~IF_clk;

  function automatic logic [7:0] model(input string p);
    string syms;
    syms = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789.,?/=";
    if (p.len() > MaxElem) return 8'h2A;
    for (int i = 0; i < 41; i++) if (morse[i] == p) return syms[i];
    return 8'h2A;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // One ms = MsClk clocks; key changes at the start, strobe on the 4th clock.
  task automatic run_ms(input int n, input logic key, input bit rdy_at_strobe = 1'b0);
    for (int m = 0; m < n; m++) begin
      for (int i = 0; i < MsClk; i++) begin
        @(negedge IF_clk);
        if (i == 0) cw_key = key;
        do1k = (i == 3);
        if (i == 3 && rdy_at_strobe && m == n - 1) char_ready = 1'b1;
      end
    end
  endtask

  task automatic send_pattern(input string p, input int t);
    for (int k = 0; k < p.len(); k++) begin
      run_ms((p[k] == "-") ? 3 * t : t, 1'b1);
      if (k != p.len() - 1) run_ms(t, 1'b0);
    end
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge IF_clk);
      #1;
      if (rstb && char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_emit: got %0h, required no character", char_data);
        end else begin
          e = exp_q.pop_front();
          check("char_data", char_data, e);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : stim
    int    t;
    string p;
    bit    word;
    rstb = 1'b0; do1k = 1'b0; enable = 1'b1; cw_key = 1'b0;
    char_ready = 1'b1; overflow_clr = 1'b0; DotOnTime = 10'd60;
    repeat (4) @(negedge IF_clk);
    check("reset_data", char_data, 8'h00);
    check("reset_valid", char_valid, 1'b0);
    check("reset_ovf", overflow, 1'b0);
    rstb = 1'b1;
    run_ms(5, 1'b0);

    // 'A' with exact emit timing: char at space=120, word space at 300
    exp_q.push_back(8'h41); exp_q.push_back(8'h20);
    run_ms(60, 1'b1); run_ms(60, 1'b0); run_ms(180, 1'b1);
    run_ms(119, 1'b0); #2 check("A_not_early", exp_q.size(), 2);
    run_ms(1, 1'b0);   #2 check("A_at_120", exp_q.size(), 1);
    run_ms(179, 1'b0); #2 check("space_not_early", exp_q.size(), 1);
    run_ms(1, 1'b0);   #2 check("space_at_300", exp_q.size(), 0);
    run_ms(20, 1'b0);

    // Held 'E', dropped 'T' and its word space
    char_ready = 1'b0;
    exp_q.push_back(8'h45);
    run_ms(60, 1'b1); run_ms(130, 1'b0);
    check("hold_valid", char_valid, 1'b1);
    check("hold_data", char_data, 8'h45);
    check("hold_no_ovf", overflow, 1'b0);
    run_ms(180, 1'b1); run_ms(130, 1'b0);
    check("drop_ovf", overflow, 1'b1);
    check("drop_data", char_data, 8'h45);
    run_ms(200, 1'b0);
    check("drop_space_data", char_data, 8'h45);
    @(negedge IF_clk); char_ready = 1'b1;
    @(negedge IF_clk);
    check("after_xfer_valid", char_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    overflow_clr = 1'b1; @(negedge IF_clk); overflow_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);

    // Transfer and new emit in the same cycle
    char_ready = 1'b0;
    exp_q.push_back(8'h45); exp_q.push_back(8'h54); exp_q.push_back(8'h20);
    run_ms(60, 1'b1); run_ms(130, 1'b0);
    run_ms(180, 1'b1); run_ms(119, 1'b0); run_ms(1, 1'b0, 1'b1);
    #2;
    check("reload_valid", char_valid, 1'b1);
    check("reload_data", char_data, 8'h54);
    check("reload_no_ovf", overflow, 1'b0);
    run_ms(250, 1'b0);

    // 7 dots at T=50 -> error character
    DotOnTime = 10'd50;
    exp_q.push_back(8'h2A); exp_q.push_back(8'h20);
    send_pattern(".......", 50);
    run_ms(100, 1'b0); #2 check("err_at_100", exp_q.size(), 1);
    run_ms(200, 1'b0);

    // DotOnTime=0 -> T=1, 3 ms mark is a dash
    DotOnTime = 10'd0;
    exp_q.push_back(8'h54); exp_q.push_back(8'h20);
    run_ms(3, 1'b1); run_ms(10, 1'b0);
    check("t1_drained", exp_q.size(), 0);

    // Enable low discards a pending element
    DotOnTime = 10'd10;
    run_ms(10, 1'b1);
    enable = 1'b0; run_ms(5, 1'b0); enable = 1'b1;
    run_ms(60, 1'b0);
    check("enable_no_emit", char_valid, 1'b0);

    // Reset during the dash of 'A', key still down when reset releases
    DotOnTime = 10'd60;
    run_ms(60, 1'b1); run_ms(60, 1'b0); run_ms(90, 1'b1);
    @(negedge IF_clk); rstb = 1'b0;
    repeat (3) @(negedge IF_clk);
    check("midreset_data", char_data, 8'h00);
    rstb = 1'b1;
    run_ms(90, 1'b1); run_ms(200, 1'b0);
    check("postreset_valid", char_valid, 1'b0);
    check("postreset_data", char_data, 8'h00);
    check("postreset_ovf", overflow, 1'b0);

    // Randomized characters against the table model
    for (int c = 0; c < 25; c++) begin
      t = $urandom_range(3, 6);
      DotOnTime = 10'(t);
      if ($urandom_range(0, 4) == 0) begin
        p = "";
        for (int k = 0, n = $urandom_range(1, 8); k < n; k++)
          p = {p, ($urandom_range(0, 1) == 1) ? "-" : "."};
      end else begin
        p = morse[$urandom_range(0, 40)];
      end
      exp_q.push_back(model(p));
      send_pattern(p, t);
      word = 1'b1;
      while (word) begin
        exp_q.push_back(8'h20);
        run_ms(7 * t, 1'b0);
        word = 1'b0;
      end
    end
    run_ms(10, 1'b0);
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cw_decoder.md
CW_DECODER -- requirements
Module: cw_decoder

Interface
REQ-001 Parameter MAX_ELEM, default 6: maximum Morse elements per character before the character is flagged as an error.
REQ-002 Parameter CNT_W, default 11: width of the mark and space duration counters, in ms ticks.
REQ-003 IF_clk  input  1  system clock, 48 MHz; all logic synchronous to its rising edge.
REQ-004 rstb  input  1  asynchronous, active-low reset.
REQ-005 do1k  input  1  1 ms strobe, one IF_clk wide.
REQ-006 enable  input  1  decoder enable; low holds the decoder idle.
REQ-007 cw_key  input  1  keyed CW signal, active high, asynchronous to IF_clk.
REQ-008 DotOnTime  input  10  nominal dot length in ms.
REQ-009 char_data  output  8  decoded ASCII character.
REQ-010 char_valid  output  1  char_data is valid.
REQ-011 char_ready  input  1  consumer accepts char_data.
REQ-012 overflow  output  1  sticky flag: a character was dropped.
REQ-013 overflow_clr  input  1  single-cycle clear for overflow.

Function
REQ-014 cw_key SHALL pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized value.
REQ-015 Effective dot time T SHALL be DotOnTime, or 1 when DotOnTime is 0.
REQ-016 Thresholds SHALL be computed at CNT_W+2 bits: dash/char threshold 2T and word threshold 5T; no truncation is permitted.
REQ-017 The state machine SHALL have 4 states:
- IDLE: no elements pending.
- MARK: key down.
- GAP: key up with elements pending.
- WORD: character emitted, waiting for the word gap.
REQ-018 On any synchronized rising key edge, from any state, the next state SHALL be MARK, and the mark counter SHALL clear to 0.
REQ-019 In MARK, each do1k SHALL increment the mark counter, which saturates at all-ones.
REQ-020 On a falling key edge in MARK:
- element = dash if mark count >= 2T, else dot;
- shift the element (dot=0, dash=1) into the code register and increment the element count;
- clear the space counter;
- go to GAP.
REQ-021 The code register SHALL hold MAX_ELEM+1 bits with a leading 1 sentinel; its reset/empty value is 1.
REQ-022 If an element arrives when the element count already equals MAX_ELEM, an error flag SHALL set and further elements SHALL be ignored until the character ends.
REQ-023 In GAP and WORD, each do1k SHALL increment the space counter, which saturates.
REQ-024 In GAP, when the space count reaches 2T, the decoder SHALL emit the looked-up character, clear the code register and element count, and go to WORD.
REQ-025 In WORD, when the space count reaches 5T, the decoder SHALL emit 0x20 once and go to IDLE.
REQ-026 Lookup SHALL cover A–Z (uppercase), 0–9, and the symbols '.', ',', '?', '/', '='. Any unmatched code or error flag SHALL produce '*' (0x2A).
REQ-027 Emit latency: char_valid SHALL assert on the IF_clk edge after the do1k cycle in which the threshold is reached.
REQ-028 Output SHALL be a single-entry holding register:
- transfer occurs on a cycle with char_valid && char_ready;
- char_valid deasserts on the cycle after the transfer unless a new emit occurs in that same cycle;
- a same-cycle new emit loads the new character and keeps char_valid high.
REQ-029 An emit while the register is full and char_ready is low SHALL discard the new character, keep char_data unchanged, and set overflow.
REQ-030 overflow SHALL clear on overflow_clr. If set and clear occur in the same cycle, set wins.
REQ-031 When enable is low, the decoder SHALL force IDLE and clear the counters, code register, element count and error flag; the output register and overflow SHALL be retained.
REQ-032 A key still down with the mark counter saturated SHALL remain in MARK and produce no emit.

Reset
REQ-033 On reset: state IDLE, counters 0, code register 1, char_data 0x00, char_valid 0, overflow 0, synchronizer flops 0.
REQ-034 Reset mid-character SHALL discard the pending elements; the first key-up after reset SHALL NOT produce an emit.

Verification
REQ-035 T=60, char_ready=1: key 60 ms on, 60 ms off, 180 ms on, then off for 400 ms -> emits 0x41 ('A') at space=120 ms, then 0x20 at space=300 ms.
REQ-036 T=60: key 60 ms on, then off for 130 ms, with char_ready held low -> 0x45 ('E') is held; a second character 'T' -> dropped, overflow=1, char_data stays 0x45.
REQ-037 T=50: 7 dots, then a 100 ms gap -> single emit of 0x2A.
REQ-038 DotOnTime=0: key 3 ms on, then off for 10 ms -> T=1; a 3 ms mark classifies as a dash; emits 0x54 ('T').
REQ-039 Assert rstb low during the second element of 'A', then a 200 ms idle gap -> no emit; all outputs at reset values.
REQ-040 char_ready=1 and a new emit in the same cycle as a pending transfer -> old character transferred, new character loaded, char_valid stays 1.
